cpu_skeleton: RTL and testbench

- Top-level wrapper of a 5-stage in-order pipelined 32-bit processor (F, D, X, M, W) with hazard stalls.
- Contains the processor core, a 32x32 register file, an instruction ROM and a data RAM.
- Only clock and reset are functional inputs; a debug read port exposes register contents to the verification bench.

---
 rtl/cpu_pkg.sv | 73 +++++++
 rtl/cpu_skeleton_regfile.sv | 38 +++
 rtl/cpu_skeleton.sv | 158 +++++++++++++++
 tb/tb_cpu_skeleton.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared ISA definitions for the cpu_skeleton pipeline: opcodes, ALU functions,
// instruction field positions, exception codes and the pipeline latch layouts.
package cpu_pkg;

    localparam int OPC_LSB   = 27;
    localparam int RD_LSB    = 22;
    localparam int RS_LSB    = 17;
    localparam int RT_LSB    = 12;
    localparam int SHAMT_LSB = 7;
    localparam int ALUOP_LSB = 2;
    localparam int IMM_W     = 17;
    localparam int TGT_W     = 27;

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_J     = 5'b00001;
    localparam logic [4:0] OP_BNE   = 5'b00010;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_SETX  = 5'b10101;

    localparam logic [4:0] ALU_ADD = 5'b00000;
    localparam logic [4:0] ALU_SUB = 5'b00001;
    localparam logic [4:0] ALU_AND = 5'b00010;
    localparam logic [4:0] ALU_OR  = 5'b00011;
    localparam logic [4:0] ALU_SLL = 5'b00100;
    localparam logic [4:0] ALU_SRA = 5'b00101;

    localparam logic [31:0] NOP      = 32'h0000_0000;
    localparam logic [31:0] EXC_ADD  = 32'd1;
    localparam logic [31:0] EXC_ADDI = 32'd2;
    localparam logic [31:0] EXC_SUB  = 32'd3;
    localparam logic [4:0]  REG_EXC  = 5'd30;

    // D/X latch: a = rs value, b = rt value, d = rd value (store data / bne operand)
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] d;
    } dx_t;

    typedef struct packed {
        logic        is_sw;
        logic        is_lw;
        logic [4:0]  dst;
        logic [31:0] res;
        logic [31:0] sdat;
    } xm_t;

    typedef struct packed {
        logic [4:0]  dst;
        logic [31:0] val;
    } mw_t;

    localparam dx_t DX_NOP = '{pc: 32'h0, ir: NOP, a: 32'h0, b: 32'h0, d: 32'h0};
    localparam xm_t XM_NOP = '{is_sw: 1'b0, is_lw: 1'b0, dst: 5'd0, res: 32'h0, sdat: 32'h0};
    localparam mw_t MW_NOP = '{dst: 5'd0, val: 32'h0};

    function automatic logic [31:0] sext_imm(input logic [31:0] ir);
        return {{(32-IMM_W){ir[IMM_W-1]}}, ir[IMM_W-1:0]};
    endfunction

    function automatic logic [31:0] zext_tgt(input logic [31:0] ir);
        return {{(32-TGT_W){1'b0}}, ir[TGT_W-1:0]};
    endfunction

    function automatic logic reg_hit(input logic used, input logic [4:0] src, input logic [4:0] dst);
        return used && (dst != 5'd0) && (src == dst);
    endfunction

endpackage

// File: rtl/cpu_skeleton_regfile.sv
// 32x32 register file: one write port (W stage), three write-through read ports (D stage)
// and a combinational debug read port. Register 0 always reads zero.
module cpu_skeleton_regfile (
    input  logic        clock,
    input  logic        reset,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  ra_rs,
    input  logic [4:0]  ra_rt,
    input  logic [4:0]  ra_rd,
    output logic [31:0] rs_val,
    output logic [31:0] rt_val,
    output logic [31:0] rd_val,
    input  logic [4:0]  dbg_addr,
    output logic [31:0] dbg_data
);

    logic [31:0] regs [32];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'h0;
            end
        end else if (we && waddr != 5'd0) begin
            regs[waddr] <= wdata;
        end
    end

    // A W-stage write to the register being read in D is returned the same cycle.
    assign rs_val = (ra_rs == 5'd0) ? 32'h0 : (we && waddr == ra_rs) ? wdata : regs[ra_rs];
    assign rt_val = (ra_rt == 5'd0) ? 32'h0 : (we && waddr == ra_rt) ? wdata : regs[ra_rt];
    assign rd_val = (ra_rd == 5'd0) ? 32'h0 : (we && waddr == ra_rd) ? wdata : regs[ra_rd];

    assign dbg_data = (dbg_addr == 5'd0) ? 32'h0 : regs[dbg_addr];

endmodule

// File: rtl/cpu_skeleton.sv
// Five-stage in-order 32-bit core (F D X M W) with instruction ROM and data RAM.
// Writeback 4 cycles after fetch; RAW hazards stall D, taken branches flush F/D and D/X.
module cpu_skeleton
    import cpu_pkg::*;
#(
    parameter string IMEM_FILE = "imem.hex",
    parameter int    MEM_AW    = 12
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  dbg_reg_addr,
    output logic [31:0] dbg_reg_data
);

    logic [31:0] imem [0:(1<<MEM_AW)-1];
    logic [31:0] dmem [0:(1<<MEM_AW)-1];

    logic [31:0] pc;
    logic [31:0] fd_ir;
    logic [31:0] fd_pc;
    dx_t         dx;
    xm_t         xm;
    mw_t         mw;

    // ---------------- D: decode, register read, hazard detection
    logic [4:0]  d_op, d_rd, d_rs, d_rt;
    logic        d_use_rs, d_use_rt, d_use_rd;
    logic [31:0] rs_val, rt_val, rd_val;
    logic        stall;
    logic [4:0]  x_dst;

    assign d_op = fd_ir[OPC_LSB +: 5];
    assign d_rd = fd_ir[RD_LSB +: 5];
    assign d_rs = fd_ir[RS_LSB +: 5];
    assign d_rt = fd_ir[RT_LSB +: 5];

    always_comb begin
        d_use_rs = 1'b0;
        d_use_rt = 1'b0;
        d_use_rd = 1'b0;
        case (d_op)
            OP_RTYPE:      begin d_use_rs = 1'b1; d_use_rt = 1'b1; end
            OP_ADDI, OP_LW: d_use_rs = 1'b1;
            OP_SW, OP_BNE: begin d_use_rs = 1'b1; d_use_rd = 1'b1; end
            default:       ;
        endcase
    end

    assign stall = reg_hit(d_use_rs, d_rs, x_dst) || reg_hit(d_use_rs, d_rs, xm.dst)
                || reg_hit(d_use_rt, d_rt, x_dst) || reg_hit(d_use_rt, d_rt, xm.dst)
                || reg_hit(d_use_rd, d_rd, x_dst) || reg_hit(d_use_rd, d_rd, xm.dst);

    cpu_skeleton_regfile u_regfile (
        .clock    (clock),
        .reset    (reset),
        .we       (mw.dst != 5'd0),
        .waddr    (mw.dst),
        .wdata    (mw.val),
        .ra_rs    (d_rs),
        .ra_rt    (d_rt),
        .ra_rd    (d_rd),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .rd_val   (rd_val),
        .dbg_addr (dbg_reg_addr),
        .dbg_data (dbg_reg_data)
    );

    // ---------------- X: ALU, overflow, branch resolution
    logic [4:0]  x_op, x_rd, x_shamt, x_aluop;
    logic [31:0] x_imm, x_opb, x_sum, x_diff, x_res, x_target;
    logic        x_ovf_add, x_ovf_sub, x_taken;

    assign x_op      = dx.ir[OPC_LSB +: 5];
    assign x_rd      = dx.ir[RD_LSB +: 5];
    assign x_shamt   = dx.ir[SHAMT_LSB +: 5];
    assign x_aluop   = dx.ir[ALUOP_LSB +: 5];
    assign x_imm     = sext_imm(dx.ir);
    assign x_opb     = (x_op == OP_RTYPE) ? dx.b : x_imm;
    assign x_sum     = dx.a + x_opb;
    assign x_diff    = dx.a - x_opb;
    assign x_ovf_add = (dx.a[31] == x_opb[31]) && (x_sum[31] != dx.a[31]);
    assign x_ovf_sub = (dx.a[31] != x_opb[31]) && (x_diff[31] != dx.a[31]);

    // x_dst is the register actually written, so overflow redirects hazards to $30.
    always_comb begin
        x_res = x_sum;
        x_dst = 5'd0;
        case (x_op)
            OP_RTYPE: begin
                x_dst = x_rd;
                case (x_aluop)
                    ALU_ADD: if (x_ovf_add) begin x_res = EXC_ADD; x_dst = REG_EXC; end
                    ALU_SUB: begin
                        x_res = x_diff;
                        if (x_ovf_sub) begin x_res = EXC_SUB; x_dst = REG_EXC; end
                    end
                    ALU_AND: x_res = dx.a & dx.b;
                    ALU_OR:  x_res = dx.a | dx.b;
                    ALU_SLL: x_res = dx.a << x_shamt;
                    ALU_SRA: x_res = $signed(dx.a) >>> x_shamt;
                    default: x_dst = 5'd0;
                endcase
            end
            OP_ADDI: begin
                x_dst = x_rd;
                if (x_ovf_add) begin x_res = EXC_ADDI; x_dst = REG_EXC; end
            end
            OP_LW:   x_dst = x_rd;
            OP_SETX: begin x_res = zext_tgt(dx.ir); x_dst = REG_EXC; end
            default: ;
        endcase
    end

    assign x_taken  = (x_op == OP_J) || (x_op == OP_BNE && dx.d != dx.a);
    assign x_target = (x_op == OP_J) ? zext_tgt(dx.ir) : dx.pc + 32'd1 + x_imm;

    // ---------------- M: data RAM
    logic [MEM_AW-1:0] m_addr;
    logic [31:0]       m_val;

    assign m_addr = xm.res[MEM_AW-1:0];
    assign m_val  = xm.is_lw ? dmem[m_addr] : xm.res;

    always_ff @(posedge clock) begin
        if (xm.is_sw) dmem[m_addr] <= xm.sdat;
    end

    // ---------------- pipeline latches; flush takes priority over stall
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc    <= 32'h0;
            fd_ir <= NOP;
            fd_pc <= 32'h0;
            dx    <= DX_NOP;
            xm    <= XM_NOP;
            mw    <= MW_NOP;
        end else begin
            xm <= '{is_sw: (x_op == OP_SW), is_lw: (x_op == OP_LW), dst: x_dst,
                    res: x_res, sdat: dx.d};
            mw <= '{dst: xm.dst, val: m_val};
            if (x_taken) begin
                pc    <= x_target;
                fd_ir <= NOP;
                fd_pc <= 32'h0;
                dx    <= DX_NOP;
            end else if (stall) begin
                dx    <= DX_NOP;
            end else begin
                pc    <= pc + 32'd1;
                fd_ir <= imem[pc[MEM_AW-1:0]];
                fd_pc <= pc;
                dx    <= '{pc: fd_pc, ir: fd_ir, a: rs_val, b: rt_val, d: rd_val};
            end
        end
    end

endmodule

// File: tb/tb_cpu_skeleton.sv
// Bench for cpu_skeleton: programs are loaded into the ROM by hierarchical write, run,
// and the register file is compared against an instruction-level interpreter.
module tb_cpu_skeleton;

    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  dbg_reg_addr;
    logic [31:0] dbg_reg_data;

    int tests = 0;
    int fails = 0;

    logic [31:0] prog [$];
    logic [31:0] m_regs [32];
    logic [31:0] m_mem [int];

    localparam longint MAXS = 64'sh7FFF_FFFF;
    localparam longint MINS = -64'sh8000_0000;

    cpu_skeleton #(.IMEM_FILE(""), .MEM_AW(12)) dut (
        .clock        (clock),
        .reset        (reset),
        .dbg_reg_addr (dbg_reg_addr),
        .dbg_reg_data (dbg_reg_data)
    );

    always #50 clock = ~clock;

    function automatic logic [31:0] enc_r(input int rd, input int rs, input int rt, input int sh, input int fn);
        return {5'd0, 5'(rd), 5'(rs), 5'(rt), 5'(sh), 5'(fn), 2'b00};
    endfunction
    function automatic logic [31:0] enc_i(input int op, input int rd, input int rs, input int imm);
        return {5'(op), 5'(rd), 5'(rs), 17'(imm)};
    endfunction
    function automatic logic [31:0] enc_t(input int op, input int t);
        return {5'(op), 27'(t)};
    endfunction

    task automatic mwr(input int r, input logic [31:0] v);
        if (r != 0) m_regs[r] = v;
    endtask

    // Sequential interpreter: every instruction completes before the next starts.
    task automatic run_model();
        int pc, steps, op, rd, rs, rt, sh, fn, addr;
        logic [31:0] ir, a, b, dv;
        longint imm, s;
        pc = 0;
        steps = 0;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        m_mem.delete();
        while (pc < prog.size() && steps < 10000) begin
            ir = prog[pc];
            op = int'(ir[31:27]); rd = int'(ir[26:22]); rs = int'(ir[21:17]);
            rt = int'(ir[16:12]); sh = int'(ir[11:7]);  fn = int'(ir[6:2]);
            imm = longint'($signed(ir[16:0]));
            a = m_regs[rs]; b = m_regs[rt]; dv = m_regs[rd];
            addr = int'((longint'(a) + imm) & 4095);
            steps++;
            pc++;
            case (op)
                0: case (fn)
                    0: begin
                        s = longint'($signed(a)) + longint'($signed(b));
                        if (s > MAXS || s < MINS) mwr(30, 32'd1); else mwr(rd, 32'(s));
                    end
                    1: begin
                        s = longint'($signed(a)) - longint'($signed(b));
                        if (s > MAXS || s < MINS) mwr(30, 32'd3); else mwr(rd, 32'(s));
                    end
                    2: mwr(rd, a & b);
                    3: mwr(rd, a | b);
                    4: mwr(rd, 32'(longint'(a) << sh));
                    5: mwr(rd, 32'(longint'($signed(a)) >>> sh));
                    default: ;
                endcase
                5: begin
                    s = longint'($signed(a)) + imm;
                    if (s > MAXS || s < MINS) mwr(30, 32'd2); else mwr(rd, 32'(s));
                end
                7: m_mem[addr] = dv;
                8: mwr(rd, m_mem.exists(addr) ? m_mem[addr] : 32'h0);
                1: pc = int'(ir[26:0]);
                2: if (dv != a) pc = pc + int'(imm);
                21: mwr(30, {5'd0, ir[26:0]});
                default: ;
            endcase
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic check_reg(input string name, input int idx, input logic [31:0] exp);
        dbg_reg_addr = 5'(idx);
        #1;
        check_val($sformatf("%s r%0d", name, idx), dbg_reg_data, exp);
    endtask

    task automatic check_all(input string name);
        for (int i = 0; i < 32; i++) check_reg(name, i, m_regs[i]);
    endtask

    task automatic check_lit(input string name, input int idx, input logic [31:0] lit);
        check_val($sformatf("%s model r%0d", name, idx), m_regs[idx], lit);
        check_reg($sformatf("%s lit", name), idx, lit);
    endtask

    task automatic load_and_reset();
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 256; i++) dut.imem[i] = (i < prog.size()) ? prog[i] : 32'h0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic run_prog(input string name);
        run_model();
        load_and_reset();
        repeat (4 * prog.size() + 30) @(negedge clock);
        check_all(name);
    endtask

    // Cycles from reset release until PC reaches 4.
    task automatic check_pc_timing(input string name, input int exp);
        int n;
        n = 0;
        run_model();
        load_and_reset();
        while (n < 40) begin
            @(posedge clock);
            #1;
            n++;
            if (dut.pc == 32'd4) break;
        end
        check_val(name, 32'(n), 32'(exp));
        repeat (30) @(negedge clock);
        check_all(name);
    endtask

    task automatic gen_random(input int body);
        int kind, pcn, rd, rs, rt;
        prog.delete();
        prog.push_back(enc_i(5, 31, 0, 256));
        for (int k = 0; k < 8; k++) begin
            prog.push_back(enc_i(7, 0, 0, k));
            prog.push_back(enc_i(7, 0, 31, k));
        end
        for (int k = 0; k < body; k++) begin
            kind = int'($urandom_range(0, 11));
            pcn  = prog.size();
            rd   = int'($urandom_range(0, 30));
            rs   = int'($urandom_range(0, 31));
            rt   = int'($urandom_range(0, 31));
            case (kind)
                0, 1, 2, 3: prog.push_back(enc_r(rd, rs, rt, int'($urandom_range(0, 31)), int'($urandom_range(0, 5))));
                4, 5:       prog.push_back(enc_i(5, rd, rs, int'($urandom_range(0, 32'h1FFFF))));
                6:          prog.push_back(enc_i(7, rd, ($urandom_range(0, 1) == 0) ? 0 : 31, int'($urandom_range(0, 7))));
                7:          prog.push_back(enc_i(8, rd, ($urandom_range(0, 1) == 0) ? 0 : 31, int'($urandom_range(0, 7))));
                8:          prog.push_back(enc_t(21, int'($urandom_range(0, 32'h7FFFFFF))));
                9, 10:      prog.push_back(enc_i(2, rd, rs, int'($urandom_range(0, 3))));
                default:    prog.push_back(enc_t(1, pcn + 1 + int'($urandom_range(0, 3))));
            endcase
        end
    endtask

    initial begin
        reset = 1'b0;
        dbg_reg_addr = 5'd0;
        for (int i = 0; i < 1024; i++) dut.imem[i] = 32'h0;
        repeat (3) @(negedge clock);

        for (int i = 0; i < 32; i++) check_reg("reset", i, 32'h0);
        check_val("reset pc", dut.pc, 32'h0);

        prog = '{enc_i(5, 1, 0, 5), enc_i(5, 2, 0, 2), enc_r(3, 1, 2, 0, 0),
                 enc_r(4, 1, 2, 0, 1), enc_r(5, 1, 0, 2, 4)};
        run_prog("alu");
        check_lit("alu", 3, 32'd7);
        check_lit("alu", 4, 32'd3);
        check_lit("alu", 5, 32'd20);

        prog = '{enc_i(5, 6, 0, 6), enc_i(5, 7, 6, 1)};
        check_pc_timing("dep stall", 6);
        check_lit("dep", 6, 32'd6);
        check_lit("dep", 7, 32'd7);
        prog = '{enc_i(5, 6, 0, 6), enc_i(5, 7, 0, 1)};
        check_pc_timing("no stall", 4);

        prog = '{enc_i(5, 1, 0, 9), enc_i(7, 1, 0, 4), enc_i(8, 8, 0, 4), enc_i(5, 9, 8, 1)};
        run_prog("mem");
        check_lit("mem", 8, 32'd9);
        check_lit("mem", 9, 32'd10);

        prog = '{enc_i(5, 1, 0, 1), enc_i(2, 1, 0, 2), enc_i(5, 4, 0, 5),
                 enc_i(5, 5, 0, 5), enc_t(21, 7)};
        run_prog("bne");
        check_lit("bne", 4, 32'd0);
        check_lit("bne", 5, 32'd0);
        check_lit("bne", 30, 32'd7);

        prog = '{enc_i(5, 1, 0, 32'hFFFF), enc_r(1, 1, 0, 15, 4), enc_i(5, 1, 1, 32'h7FFF),
                 enc_i(5, 2, 0, 1), enc_r(3, 1, 2, 0, 0), enc_r(10, 30, 0, 0, 0),
                 enc_i(5, 4, 1, 1), enc_r(11, 30, 0, 0, 0), enc_i(5, 6, 0, -2),
                 enc_r(5, 6, 1, 0, 1), enc_i(5, 12, 0, 3), enc_r(0, 12, 12, 0, 0)};
        run_prog("ovf");
        check_lit("ovf", 1, 32'h7FFF_FFFF);
        check_lit("ovf", 3, 32'd0);
        check_lit("ovf", 10, 32'd1);
        check_lit("ovf", 4, 32'd0);
        check_lit("ovf", 11, 32'd2);
        check_lit("ovf", 5, 32'd0);
        check_lit("ovf", 30, 32'd3);
        check_lit("ovf", 12, 32'd3);
        check_lit("ovf", 0, 32'd0);

        for (int p = 0; p < 10; p++) begin
            gen_random(30);
            run_prog($sformatf("rand%0d", p));
        end

        gen_random(30);
        run_model();
        load_and_reset();
        repeat (40) @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 32; i++) check_reg("midrun reset", i, 32'h0);
        @(negedge clock);
        reset = 1'b1;
        repeat (4 * prog.size() + 30) @(negedge clock);
        check_all("restart");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
